tt_um_instruction_register: RTL
===============================

// Module: tt_um_instruction_register
// PURPOSE
// - Instruction register (IR) of the 8-bit SAP-style CPU. Sits directly upstream of the control block.
// - Captures the fetched instruction byte from the shared bus.
// - Supplies opcode[3:0] to the control block.
// - Drives the operand nibble back onto the bus for address/jump micro-ops.
// - Also tracks halt state, illegal opcodes, bus conflicts and a fetch count for debug.
// PARAMETERS
// - RESET_INSTR  8'h10  IR value after reset (NOP, operand 0); keeps control T1 PC increment alive
// - CNT_WIDTH    8      width of fetch counter instr_count
// PORTS
// - clk          in   1          system clock; all state updates on posedge
// - resetn       in   1          synchronous active-low reset
// - bus_in       in   8          shared bus value (instruction byte during fetch)
// - ir_load_n    in   1          \L_I from control word bit 7; 0 = capture bus_in
// - ir_en_n      in   1          \E_I from control word bit 6; 0 = drive operand on bus
// - opcode       out  4          ir[7:4] to control block
// - operand      out  4          ir[3:0]
// - bus_out      out  8          {4'b0, ir[3:0]}
// - bus_oe       out  1          bus driver enable
// - halted       out  1          sticky; HLT (opcode 0) has been loaded
// - illegal_op   out  1          current opcode is outside 0..7
// - bus_conflict out  1          sticky; load and enable were asserted in the same cycle
// - instr_count  out  CNT_WIDTH  number of accepted loads, modulo 2^CNT_WIDTH
// BEHAVIOUR
// - Synchronous reset: resetn==0 at posedge clk has priority over every other input. The reset state is:
//   - ir=RESET_INSTR
//   - halted=0
//   - bus_conflict=0
//   - instr_count=0
// - Reset values of the outputs follow from that state:
//   - opcode=4'h1, operand=0, illegal_op=0
//   - bus_out=0; bus_oe follows ir_en_n, including during reset.
// - A reset asserted mid-instruction discards the current IR contents at that edge.
// - Load: ir_load_n==0 && !halted at posedge clk -> ir<=bus_in and instr_count<=instr_count+1.
//   - The new value is visible on opcode/operand the cycle after the edge (1-cycle latency).
//   - The control block samples opcode combinationally.
// - Halt: the load edge that captures an opcode of 4'h0 also sets halted=1 at that same edge.
//   - While halted, loads are ignored: ir and instr_count hold.
//   - Only resetn clears halted.
// - Counter: instr_count wraps from 2^CNT_WIDTH-1 to 0. It does not saturate.
// - Operand drive is combinational: bus_oe = ~ir_en_n; bus_out = {4'b0, ir[3:0]}.
//   - bus_out is a don't-care when bus_oe==0 but is held at that value anyway.
// - Simultaneous ir_load_n==0 and ir_en_n==0:
//   - The load still occurs (if not halted).
//   - bus_out shows the pre-edge operand during that cycle.
//   - bus_conflict is set at the edge, and stays set until reset.
// - illegal_op = ir[7], combinational from the register.
//   - The illegal opcode is not altered; the control block treats it as a no-op.
//   - It does not set halted.
// - No other state. Outputs other than bus_oe and bus_out are pure functions of registers: no combinational path from bus_in.
// TESTING
// 1. Reset: resetn=0 for 2 cycles -> opcode=1, operand=0, halted=0, instr_count=0, illegal_op=0, bus_conflict=0.
// 2. Load: bus_in=8'h2E, ir_load_n=0 for 1 cycle -> next cycle opcode=2, operand=E, instr_count=1. ir_en_n=0 -> bus_oe=1, bus_out=8'h0E.
// 3. Halt: load 8'h07 -> halted=1. Then load 8'h45 -> ir stays 8'h07, instr_count does not advance. resetn=0 -> halted=0, opcode=1.
// 4. Illegal/wrap: CNT_WIDTH=8.
//    - Load 8'h9A -> illegal_op=1, halted=0.
//    - 256 loads of 8'h10 from count 0 -> instr_count back to 0.
// 5. Conflict: ir=8'h23; ir_load_n=0, ir_en_n=0, bus_in=8'h5C -> that cycle bus_out=8'h03. Next: opcode=5, bus_conflict=1 (sticky).
// 6. Reset vs load: resetn=0 with ir_load_n=0, bus_in=8'h00 -> ir=8'h10, halted=0, instr_count=0.

Source files
------------

// File: rtl/tt_um_instruction_register.sv
// Instruction register for the 8-bit SAP-style CPU: captures the fetched byte, feeds opcode to control, drives operand to bus.
// Latency: a load is visible on opcode/operand one cycle after the capturing edge; bus_oe/bus_out are combinational.
// Backpressure: none; loads are accepted every cycle ir_load_n is low unless halted, and ignored while halted.
module tt_um_instruction_register #(
    parameter logic [7:0] RESET_INSTR = 8'h10,
    parameter int         CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           bus_in,
    input  logic                 ir_load_n,
    input  logic                 ir_en_n,
    output logic [3:0]           opcode,
    output logic [3:0]           operand,
    output logic [7:0]           bus_out,
    output logic                 bus_oe,
    output logic                 halted,
    output logic                 illegal_op,
    output logic                 bus_conflict,
    output logic [CNT_WIDTH-1:0] instr_count
);

    logic [7:0]           ir_q,       ir_d;
    logic                 halted_q,   halted_d;
    logic                 conflict_q, conflict_d;
    logic [CNT_WIDTH-1:0] count_q,    count_d;

    // A capture happens only when the load strobe is active and the CPU has not halted.
    logic load_acc;
    assign load_acc = ~ir_load_n & ~halted_q;

    // Next-state: capture, halt detection on HLT capture, sticky conflict flag, wrapping fetch counter.
    always_comb begin
        ir_d       = ir_q;
        halted_d   = halted_q;
        conflict_d = conflict_q;
        count_d    = count_q;
        if (load_acc) begin
            ir_d    = bus_in;
            count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (bus_in[7:4] == 4'h0) begin
                halted_d = 1'b1;
            end
        end
        // Load and drive in the same cycle is a bus fight, flagged even when the load itself is ignored.
        if (!ir_load_n && !ir_en_n) begin
            conflict_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset taking priority over any load.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ir_q       <= RESET_INSTR;
            halted_q   <= 1'b0;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            ir_q       <= ir_d;
            halted_q   <= halted_d;
            conflict_q <= conflict_d;
            count_q    <= count_d;
        end
    end

    // Outputs: all register-derived except the bus driver enable, which tracks ir_en_n directly.
    assign opcode       = ir_q[7:4];
    assign operand      = ir_q[3:0];
    assign bus_out      = {4'b0000, ir_q[3:0]};
    assign bus_oe       = ~ir_en_n;
    assign halted       = halted_q;
    assign illegal_op   = ir_q[7];
    assign bus_conflict = conflict_q;
    assign instr_count  = count_q;

endmodule
